vx_tcache_serializer: RTL
=========================

# vx_tcache_serializer

Sits directly downstream of the pipeline's texture-cache request/response ports, between the core and a single-port texture cache. It accepts one warp-wide tcache request (up to `NUM_REQS` lanes), issues the active lanes to the texture cache one at a time, and collects the per-lane read responses, which may return in any order. It then returns one merged warp response with a thread mask. One warp request is in flight at a time.

## Interface
Parameters:
- `NUM_REQS`, 4: lanes per warp request (power of 2, ≥2); `LANE_BITS` = log2(`NUM_REQS`)
- `ADDR_WIDTH`, 30: word address width
- `DATA_WIDTH`, 32: word width; byteen width = `DATA_WIDTH`/8
- `TAG_WIDTH`, 16: core request tag width

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset
- `core_req_valid` in `NUM_REQS`: per-lane request valid
- `core_req_rw` in `NUM_REQS`: 1 = write, 0 = read
- `core_req_byteen` in `NUM_REQS`×(`DATA_WIDTH`/8): byte enables
- `core_req_addr` in `NUM_REQS`×`ADDR_WIDTH`: word addresses
- `core_req_data` in `NUM_REQS`×`DATA_WIDTH`: write data
- `core_req_tag` in `NUM_REQS`×`TAG_WIDTH`: request tags
- `core_req_ready` out `NUM_REQS`: per-lane ready
- `core_rsp_valid` out 1: merged response valid
- `core_rsp_tmask` out `NUM_REQS`: lanes carrying read data
- `core_rsp_data` out `NUM_REQS`×`DATA_WIDTH`: per-lane read data
- `core_rsp_tag` out `TAG_WIDTH`: warp tag
- `core_rsp_ready` in 1: consumer ready
- `mem_req_valid` out 1; `mem_req_rw` out 1; `mem_req_byteen` out `DATA_WIDTH`/8; `mem_req_addr` out `ADDR_WIDTH`; `mem_req_data` out `DATA_WIDTH`; `mem_req_tag` out `LANE_BITS` (lane index); `mem_req_ready` in 1
- `mem_rsp_valid` in 1; `mem_rsp_data` in `DATA_WIDTH`; `mem_rsp_tag` in `LANE_BITS`; `mem_rsp_ready` out 1

## Operation
FSM states: IDLE, SEND, WAIT, RSP.

- **IDLE**
  - `core_req_ready` = all ones.
  - On a cycle with any `core_req_valid`, register:
    - `send_mask` = `core_req_valid`
    - `rd_mask` = `core_req_valid & ~core_req_rw`
    - each lane's addr/data/byteen/rw
    - `core_req_tag` of the lowest-index valid lane
  - Clear the data buffer. Go to SEND.
- **SEND**
  - `mem_req_*` presents the lowest set bit of `send_mask`; `mem_req_tag` = that lane's index.
  - On `mem_req_valid & mem_req_ready`, clear that bit.
  - After the last handshake:
    - go to WAIT if any read is outstanding;
    - else go to RSP if `rd_mask` ≠ 0;
    - else (all writes) go to IDLE.
- **Response capture** (SEND and WAIT)
  - `mem_rsp_ready` = 1.
  - On `mem_rsp_valid`, write `mem_rsp_data` into buffer lane `mem_rsp_tag` and clear that lane's pending bit.
  - `pending` is set for read lanes in the IDLE accept cycle.
- **WAIT**: go to RSP on the edge that clears the last pending bit.
- **RSP**
  - `core_rsp_valid` = 1; `core_rsp_tmask` = `rd_mask`; `core_rsp_data` = buffer, with lanes not in `rd_mask` = 0.
  - All RSP outputs stay stable until `core_rsp_ready`, then go to IDLE.
- **Unexpected response**: a response for a non-pending lane is ignored (simulation assertion fires).
- **Overlap**: a response arriving in the same cycle as the final send handshake is captured. The next state uses the post-update masks.

## Timing
- **While `reset` is high**:
  - all valid/ready outputs are 0 (`core_req_ready`, `core_rsp_valid`, `mem_req_valid`, `mem_rsp_ready`);
  - state = IDLE; masks and buffer are cleared.
- **Reset mid-operation**: outstanding lanes are dropped; late responses after reset are not accepted (`mem_rsp_ready` = 0 in IDLE).
- **Accept to memory**: accept at edge T; first `mem_req_valid` in cycle T+1.
- **Send rate**: one lane per cycle while `mem_req_ready` = 1.
- **Best case, N read lanes**: with `mem_req_ready` = 1 and each response arriving in the cycle after its request handshake, `core_rsp_valid` rises in cycle T+N+2.
- **`mem_req_*` stability**: stable while `mem_req_valid` & !`mem_req_ready`.
- **Backpressure**: `core_req_ready` = 0 in SEND, WAIT and RSP.
- **Next request**: the earliest new accept is the cycle after the RSP handshake, or the cycle after the final write send.

## Test plan
- **Four-lane read, reversed responses**: 4-lane read, addrs 0x10..0x13, tag 0x00AB; memory returns lane tags 3,2,1,0 with data 0xD3..0xD0 → one `core_rsp` with tmask 4'b1111, data[i] = 0xD0+i, tag 0x00AB.
- **Mixed read/write**: valid 4'b1101, rw 4'b0101 (lanes 0, 2 write; lane 3 read) → mem requests in lane order 0, 2, 3; tmask 4'b1000; lanes 0–2 data = 0.
- **All writes**: valid 4'b0011, rw 4'b0011 → two mem writes, no `core_rsp_valid`; `core_req_ready` returns high the cycle after the second handshake.
- **Backpressure**:
  - `mem_req_ready` toggles 0/1: each lane is issued exactly once with stable fields while stalled.
  - `core_rsp_ready` held low 3 cycles: response is stable, then handshakes once.
- **Best-case latency**: single-cycle memory, 4 read lanes accepted at T → `core_rsp_valid` at T+6.
- **Reset mid-WAIT**: assert `reset` with 2 pending lanes → all outputs 0; after release, `core_req_ready` = 4'b1111, and a fresh request completes correctly.

Source files
------------

// File: rtl/vx_tcache_serializer_if.sv
// Texture-cache serializer bus: the warp-wide core request/response side and the
// single-lane texture-cache side, grouped so the serializer takes one port.
interface vx_tcache_serializer_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 16
);
  localparam int LANE_BITS    = $clog2(NUM_REQS);
  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQS-1:0]                    core_req_valid;
  logic [NUM_REQS-1:0]                    core_req_rw;
  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]  core_req_byteen;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]    core_req_addr;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    core_req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]     core_req_tag;
  logic [NUM_REQS-1:0]                    core_req_ready;

  logic                                   core_rsp_valid;
  logic [NUM_REQS-1:0]                    core_rsp_tmask;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    core_rsp_data;
  logic [TAG_WIDTH-1:0]                   core_rsp_tag;
  logic                                   core_rsp_ready;

  logic                                   mem_req_valid;
  logic                                   mem_req_rw;
  logic [BYTEEN_WIDTH-1:0]                mem_req_byteen;
  logic [ADDR_WIDTH-1:0]                  mem_req_addr;
  logic [DATA_WIDTH-1:0]                  mem_req_data;
  logic [LANE_BITS-1:0]                   mem_req_tag;
  logic                                   mem_req_ready;

  logic                                   mem_rsp_valid;
  logic [DATA_WIDTH-1:0]                  mem_rsp_data;
  logic [LANE_BITS-1:0]                   mem_rsp_tag;
  logic                                   mem_rsp_ready;

  modport slave (
    input  core_req_valid, core_req_rw, core_req_byteen, core_req_addr,
           core_req_data, core_req_tag, core_rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output core_req_ready, core_rsp_valid, core_rsp_tmask, core_rsp_data,
           core_rsp_tag, mem_req_valid, mem_req_rw, mem_req_byteen,
           mem_req_addr, mem_req_data, mem_req_tag, mem_rsp_ready
  );

  modport master (
    output core_req_valid, core_req_rw, core_req_byteen, core_req_addr,
           core_req_data, core_req_tag, core_rsp_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  core_req_ready, core_rsp_valid, core_rsp_tmask, core_rsp_data,
           core_rsp_tag, mem_req_valid, mem_req_rw, mem_req_byteen,
           mem_req_addr, mem_req_data, mem_req_tag, mem_rsp_ready
  );
endinterface

// File: rtl/vx_tcache_serializer.sv
// Serializes one warp-wide texture-cache request into per-lane cache accesses and
// merges the out-of-order per-lane read responses back into a single warp response.
module vx_tcache_serializer #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 16
) (
  input  logic clk,
  input  logic reset,
  vx_tcache_serializer_if.slave bus
);
  localparam int LANE_BITS    = $clog2(NUM_REQS);
  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RSP} state_t;

  state_t r_state;
  state_t w_next_state;

  logic [NUM_REQS-1:0]                   r_send_mask;
  logic [NUM_REQS-1:0]                   r_rd_mask;
  logic [NUM_REQS-1:0]                   r_pending;
  logic [NUM_REQS-1:0]                   r_rw;
  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0] r_byteen;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]   r_addr;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   r_data;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   r_buf;
  logic [TAG_WIDTH-1:0]                  r_tag;

  logic                 w_accept;
  logic                 w_send_fire;
  logic                 w_rsp_fire;
  logic [LANE_BITS-1:0] w_send_idx;
  logic [NUM_REQS-1:0]  w_send_next;
  logic [NUM_REQS-1:0]  w_pending_next;

  function automatic logic [LANE_BITS-1:0] lowest_idx(input logic [NUM_REQS-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = LANE_BITS'(i);
    end
  endfunction

  // Post-update masks: the next-state decision must see this cycle's send and response.
  always_comb begin
    w_accept       = (r_state == S_IDLE) && !reset && (|bus.core_req_valid);
    w_send_idx     = lowest_idx(r_send_mask);
    w_send_fire    = (r_state == S_SEND) && bus.mem_req_ready;
    w_rsp_fire     = ((r_state == S_SEND) || (r_state == S_WAIT)) &&
                     bus.mem_rsp_valid && r_pending[bus.mem_rsp_tag];
    w_send_next    = r_send_mask;
    w_pending_next = r_pending;
    if (w_send_fire) w_send_next[w_send_idx] = 1'b0;
    if (w_rsp_fire) w_pending_next[bus.mem_rsp_tag] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_SEND;
      S_SEND: begin
        if (w_send_next == '0) begin
          if (w_pending_next != '0)  w_next_state = S_WAIT;
          else if (r_rd_mask != '0)  w_next_state = S_RSP;
          else                       w_next_state = S_IDLE;
        end
      end
      S_WAIT: if (w_pending_next == '0) w_next_state = S_RSP;
      S_RSP:  if (bus.core_rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_send_mask <= '0;
      r_rd_mask   <= '0;
      r_pending   <= '0;
      r_buf       <= '0;
    end else if (w_accept) begin
      r_send_mask <= bus.core_req_valid;
      r_rd_mask   <= bus.core_req_valid & ~bus.core_req_rw;
      r_pending   <= bus.core_req_valid & ~bus.core_req_rw;
      r_buf       <= '0;
    end else begin
      r_send_mask <= w_send_next;
      r_pending   <= w_pending_next;
      if (w_rsp_fire) r_buf[bus.mem_rsp_tag] <= bus.mem_rsp_data;
    end
  end

  // Lane payload only matters while its send bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rw     <= bus.core_req_rw;
      r_byteen <= bus.core_req_byteen;
      r_addr   <= bus.core_req_addr;
      r_data   <= bus.core_req_data;
      r_tag    <= bus.core_req_tag[lowest_idx(bus.core_req_valid)];
    end
  end

  always_comb begin
    bus.core_req_ready = '0;
    bus.core_rsp_valid = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_rsp_ready  = 1'b0;
    bus.core_rsp_tmask = r_rd_mask;
    bus.core_rsp_tag   = r_tag;
    for (int i = 0; i < NUM_REQS; i++) begin
      bus.core_rsp_data[i] = r_rd_mask[i] ? r_buf[i] : '0;
    end
    bus.mem_req_rw     = r_rw[w_send_idx];
    bus.mem_req_byteen = r_byteen[w_send_idx];
    bus.mem_req_addr   = r_addr[w_send_idx];
    bus.mem_req_data   = r_data[w_send_idx];
    bus.mem_req_tag    = w_send_idx;
    if (!reset) begin
      case (r_state)
        S_IDLE: bus.core_req_ready = '1;
        S_SEND: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_rsp_ready = 1'b1;
        end
        S_WAIT: bus.mem_rsp_ready = 1'b1;
        S_RSP:  bus.core_rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // A response for a lane that is not outstanding is dropped by the capture logic.
  a_rsp_pending: assert property (@(posedge clk) disable iff (reset)
    (bus.mem_rsp_valid && bus.mem_rsp_ready) |-> r_pending[bus.mem_rsp_tag]);

endmodule
